// File: rtl/kgp_alu_pkg.sv
// Shared encodings for the KGP-RISC ALU issue path: ALU control codes, opcodes/functs,
// issue FSM states and flag bit positions.
package kgp_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_COMP = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_ZERO = 4'b0111;
  localparam logic [3:0] ALU_SLLV = 4'b1100;
  localparam logic [3:0] ALU_SRLV = 4'b1101;
  localparam logic [3:0] ALU_SRAV = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_COMPI = 6'b000010;

  localparam logic [4:0] FN_ADD   = 5'b00000;
  localparam logic [4:0] FN_COMP  = 5'b00001;
  localparam logic [4:0] FN_AND   = 5'b00010;
  localparam logic [4:0] FN_XOR   = 5'b00011;
  localparam logic [4:0] FN_SHLL  = 5'b00100;
  localparam logic [4:0] FN_SHRL  = 5'b00101;
  localparam logic [4:0] FN_SHRA  = 5'b00110;
  localparam logic [4:0] FN_SHLLV = 5'b01100;
  localparam logic [4:0] FN_SHRLV = 5'b01101;
  localparam logic [4:0] FN_SHRAV = 5'b01110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } issue_state_t;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, register-file and ALU signals of the issue controller;
// master = controller side, slave = fetch/register-file/ALU side.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
);
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              instr_ready;
  logic [REG_AW-1:0] rf_raddr1;
  logic [REG_AW-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [4:0]        alu_shamt;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        flags;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_carry,
    output instr_ready, rf_raddr1, rf_raddr2, alu_in1, alu_in2, alu_shamt, alu_ctrl,
           rf_we, rf_waddr, rf_wdata, flags, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_carry,
    input  instr_ready, rf_raddr1, rf_raddr2, alu_in1, alu_in2, alu_shamt, alu_ctrl,
           rf_we, rf_waddr, rf_wdata, flags, done, illegal
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational decode of opcode/funct into ALU control, immediate select and legality.
// Illegal encodings report ALU_ZERO so nothing downstream ever sees a stray opcode.
module alu_funct_decode
  import kgp_alu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       use_imm,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ZERO;
    use_imm  = 1'b0;
    legal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:   alu_ctrl = ALU_ADD;
          FN_COMP:  alu_ctrl = ALU_COMP;
          FN_AND:   alu_ctrl = ALU_AND;
          FN_XOR:   alu_ctrl = ALU_XOR;
          FN_SHLL:  alu_ctrl = ALU_SLL;
          FN_SHRL:  alu_ctrl = ALU_SRL;
          FN_SHRA:  alu_ctrl = ALU_SRA;
          FN_SHLLV: alu_ctrl = ALU_SLLV;
          FN_SHRLV: alu_ctrl = ALU_SRLV;
          FN_SHRAV: alu_ctrl = ALU_SRAV;
          default:  legal    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_ctrl = ALU_ADD;
        use_imm  = 1'b1;
        legal    = 1'b1;
      end
      OP_COMPI: begin
        alu_ctrl = ALU_COMP;
        use_imm  = 1'b1;
        legal    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one KGP-RISC ALU instruction: read rs/rt, drive ALU, write result to rs, update flags.
// Accept-to-writeback 3 cycles, one instruction per 4; instr_ready low while busy, instr_valid then ignored.
module alu_issue_ctrl
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_ctrl_if.master  bus
);

  issue_state_t      state;
  logic [REG_AW-1:0] rs_q;
  logic [15:0]       imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              use_imm_q;
  logic              carry_stg;
  logic [REG_AW-1:0] raddr1_q;
  logic [REG_AW-1:0] raddr2_q;

  logic [3:0]        dec_ctrl;
  logic              dec_use_imm;
  logic              dec_legal;
  logic [REG_AW-1:0] rs_in;
  logic [REG_AW-1:0] rt_in;
  logic              accept;

  assign rs_in  = bus.instr[25:21];
  assign rt_in  = bus.instr[20:16];
  assign accept = (state == ST_IDLE) && bus.instr_valid;

  alu_funct_decode u_decode (
    .op       (bus.instr[31:26]),
    .funct    (bus.instr[4:0]),
    .alu_ctrl (dec_ctrl),
    .use_imm  (dec_use_imm),
    .legal    (dec_legal)
  );

  // The register file samples its address on the accept edge, so the read
  // addresses bypass straight from the incoming instruction in that cycle.
  assign bus.rf_raddr1 = accept ? rs_in : raddr1_q;
  assign bus.rf_raddr2 = accept ? rt_in : raddr2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rs_q            <= '0;
      imm_q           <= '0;
      ctrl_q          <= ALU_ZERO;
      use_imm_q       <= 1'b0;
      carry_stg       <= 1'b0;
      raddr1_q        <= '0;
      raddr2_q        <= '0;
      bus.instr_ready <= 1'b1;
      bus.alu_in1     <= '0;
      bus.alu_in2     <= '0;
      bus.alu_shamt   <= '0;
      bus.alu_ctrl    <= ALU_ZERO;
      bus.rf_we       <= 1'b0;
      bus.rf_waddr    <= '0;
      bus.rf_wdata    <= '0;
      bus.flags       <= '0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.rf_we   <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            raddr1_q <= rs_in;
            raddr2_q <= rt_in;
            if (dec_legal) begin
              rs_q            <= rs_in;
              imm_q           <= bus.instr[15:0];
              ctrl_q          <= dec_ctrl;
              use_imm_q       <= dec_use_imm;
              bus.instr_ready <= 1'b0;
              state           <= ST_READ;
            end else begin
              bus.illegal <= 1'b1;
            end
          end
        end
        ST_READ: begin
          bus.alu_in1   <= bus.rf_rdata1;
          bus.alu_in2   <= use_imm_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : bus.rf_rdata2;
          bus.alu_shamt <= imm_q[15:11];
          bus.alu_ctrl  <= ctrl_q;
          state         <= ST_EXEC;
        end
        ST_EXEC: begin
          bus.rf_wdata <= bus.alu_out;
          // Only adds define a carry; other ALU ops may leave junk on alu_carry.
          carry_stg    <= bus.alu_carry && (ctrl_q == ALU_ADD);
          bus.rf_we    <= 1'b1;
          bus.rf_waddr <= rs_q;
          bus.done     <= 1'b1;
          state        <= ST_WB;
        end
        ST_WB: begin
          bus.flags[FLAG_C] <= carry_stg;
          bus.flags[FLAG_Z] <= (bus.rf_wdata == '0);
          bus.flags[FLAG_S] <= bus.rf_wdata[DATA_W-1];
          bus.instr_ready   <= 1'b1;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with an instruction-level reference model and
// environment models of the synchronous register file and the ALU.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic do_load = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) bus ();

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- environment: register file and ALU ----------------
  logic [31:0] init_val [32];
  logic [31:0] rf [32];

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val[i];
    end else if (bus.rf_we) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    bus.rf_rdata1 <= rf[bus.rf_raddr1];
    bus.rf_rdata2 <= rf[bus.rf_raddr2];
  end

  always_comb begin
    bus.alu_out   = 32'd0;
    bus.alu_carry = ~(bus.alu_in1[0] ^ bus.alu_in2[0]);
    case (bus.alu_ctrl)
      4'b0000: {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
      4'b0001: bus.alu_out = ~bus.alu_in2 + 32'd1;
      4'b0010: bus.alu_out = bus.alu_in1 & bus.alu_in2;
      4'b0011: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      4'b0100: bus.alu_out = bus.alu_in1 << bus.alu_shamt;
      4'b0101: bus.alu_out = bus.alu_in1 >> bus.alu_shamt;
      4'b0110: bus.alu_out = 32'($signed(bus.alu_in1) >>> bus.alu_shamt);
      4'b1100: bus.alu_out = (bus.alu_in2 > 32'd31) ? 32'd0 : bus.alu_in1 << bus.alu_in2[4:0];
      4'b1101: bus.alu_out = (bus.alu_in2 > 32'd31) ? 32'd0 : bus.alu_in1 >> bus.alu_in2[4:0];
      4'b1110: bus.alu_out = (bus.alu_in2 > 32'd31) ? {32{bus.alu_in1[31]}}
                                                     : 32'($signed(bus.alu_in1) >>> bus.alu_in2[4:0]);
      default: ;
    endcase
  end

  // ---------------- reference model (instruction level) ----------------
  function automatic bit ref_legal(input logic [31:0] ins);
    if (ins[31:26] == 6'd1 || ins[31:26] == 6'd2) return 1'b1;
    if (ins[31:26] != 6'd0) return 1'b0;
    return (ins[4:0] <= 5'd6) || (ins[4:0] >= 5'd12 && ins[4:0] <= 5'd14);
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [31:0] ins);
    if (ins[31:26] == 6'd1) return 4'b0000;
    if (ins[31:26] == 6'd2) return 4'b0001;
    case (ins[4:0])
      5'd0: return 4'b0000;  5'd1: return 4'b0001;  5'd2: return 4'b0010;
      5'd3: return 4'b0011;  5'd4: return 4'b0100;  5'd5: return 4'b0101;
      5'd6: return 4'b0110;  5'd12: return 4'b1100; 5'd13: return 4'b1101;
      5'd14: return 4'b1110;
      default: return 4'b0111;
    endcase
  endfunction

  // {carry, result} of rs op (rt | imm); carry is only defined by the add forms.
  function automatic logic [32:0] ref_result(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] imm;
    logic [4:0]  sh;
    imm = {{16{ins[15]}}, ins[15:0]};
    sh  = ins[15:11];
    if (ins[31:26] == 6'd1) return {1'b0, a} + {1'b0, imm};
    if (ins[31:26] == 6'd2) return {1'b0, 32'd0 - imm};
    case (ins[4:0])
      5'd0:  return {1'b0, a} + {1'b0, b};
      5'd1:  return {1'b0, 32'd0 - b};
      5'd2:  return {1'b0, a & b};
      5'd3:  return {1'b0, a ^ b};
      5'd4:  return {1'b0, a << sh};
      5'd5:  return {1'b0, a >> sh};
      5'd6:  return {1'b0, 32'($signed(a) >>> sh)};
      5'd12: return {1'b0, a << b};
      5'd13: return {1'b0, a >> b};
      5'd14: return {1'b0, 32'($signed(a) >>> b)};
      default: return 33'd0;
    endcase
  endfunction

  logic [31:0] mreg [32];
  int          cyc = 0;
  bit          pend = 1'b0, flag_pend = 1'b0, ill_next = 1'b0, ill_lit_done = 1'b0;
  int          pend_at, flags_at, flags_idx, n_ret = 0;
  logic [4:0]  p_waddr, p_shamt;
  logic [31:0] p_wdata, p_in1, p_in2;
  logic [3:0]  p_ctrl;
  logic [2:0]  p_flags, flags_next, m_flags = 3'b000;
  bit          ready_exp, we_exp;
  logic [32:0] res;

  // Hand-computed expectations for the four directed instructions, in issue order.
  logic [3:0]  lit_ctrl  [4] = '{4'b0000, 4'b1100, 4'b0000, 4'b0110};
  logic [31:0] lit_in2   [4] = '{32'h1, 32'd33, 32'hFFFF_FFF6, 32'h0};
  logic [4:0]  lit_shamt [4] = '{5'd0, 5'd0, 5'd31, 5'd4};
  logic [4:0]  lit_waddr [4] = '{5'd3, 5'd6, 5'd2, 5'd5};
  logic [31:0] lit_wdata [4] = '{32'h0, 32'h0, 32'h0, 32'hF800_0000};
  logic [2:0]  lit_flags [4] = '{3'b110, 3'b010, 3'b110, 3'b001};

  always @(negedge clk) begin
    if (do_load) for (int i = 0; i < 32; i++) mreg[i] = init_val[i];
    if (!rst_n) begin
      pend = 1'b0; flag_pend = 1'b0; ill_next = 1'b0; m_flags = 3'b000;
      chk("rst_instr_ready", bus.instr_ready, 1'b1);
      chk("rst_rf_we",       bus.rf_we,       1'b0);
      chk("rst_done",        bus.done,        1'b0);
      chk("rst_illegal",     bus.illegal,     1'b0);
      chk("rst_flags",       bus.flags,       3'b000);
      chk("rst_alu_ctrl",    bus.alu_ctrl,    4'b0111);
      chk("rst_alu_in1",     bus.alu_in1,     32'd0);
      chk("rst_alu_in2",     bus.alu_in2,     32'd0);
      chk("rst_alu_shamt",   bus.alu_shamt,   5'd0);
      chk("rst_rf_wdata",    bus.rf_wdata,    32'd0);
      chk("rst_rf_waddr",    bus.rf_waddr,    5'd0);
      chk("rst_rf_raddr1",   bus.rf_raddr1,   5'd0);
      chk("rst_rf_raddr2",   bus.rf_raddr2,   5'd0);
    end else begin
      cyc++;
      if (flag_pend && cyc == flags_at) begin
        m_flags   = flags_next;
        flag_pend = 1'b0;
        if (flags_idx < 4) chk("lit_flags", bus.flags, lit_flags[flags_idx]);
      end
      ready_exp = !pend;
      chk("instr_ready", bus.instr_ready, ready_exp);
      chk("illegal",     bus.illegal,     ill_next);
      chk("flags",       bus.flags,       m_flags);
      if (ill_next && !ill_lit_done) begin
        ill_lit_done = 1'b1;
        chk("lit_ill_pulse", bus.illegal,     1'b1);
        chk("lit_ill_flags", bus.flags,       3'b001);
        chk("lit_ill_ready", bus.instr_ready, 1'b1);
        chk("lit_ill_no_we", bus.rf_we,       1'b0);
      end
      we_exp = pend && (cyc == pend_at);
      chk("rf_we", bus.rf_we, we_exp);
      chk("done",  bus.done,  we_exp);
      if (pend && cyc == pend_at - 1) begin
        chk("alu_ctrl",  bus.alu_ctrl,  p_ctrl);
        chk("alu_in1",   bus.alu_in1,   p_in1);
        chk("alu_in2",   bus.alu_in2,   p_in2);
        chk("alu_shamt", bus.alu_shamt, p_shamt);
        if (n_ret < 4) begin
          chk("lit_alu_ctrl",  bus.alu_ctrl,  lit_ctrl[n_ret]);
          chk("lit_alu_in2",   bus.alu_in2,   lit_in2[n_ret]);
          chk("lit_alu_shamt", bus.alu_shamt, lit_shamt[n_ret]);
        end
      end
      if (we_exp) begin
        chk("rf_waddr", bus.rf_waddr, p_waddr);
        chk("rf_wdata", bus.rf_wdata, p_wdata);
        if (n_ret < 4) begin
          chk("lit_rf_waddr", bus.rf_waddr, lit_waddr[n_ret]);
          chk("lit_rf_wdata", bus.rf_wdata, lit_wdata[n_ret]);
        end
        mreg[p_waddr] = p_wdata;
        flag_pend  = 1'b1;
        flags_at   = cyc + 1;
        flags_next = p_flags;
        flags_idx  = n_ret;
        n_ret++;
        pend = 1'b0;
      end
      // Outcome of the coming edge, from the inputs now held stable.
      ill_next = ready_exp && bus.instr_valid && !ref_legal(bus.instr);
      if (ready_exp && bus.instr_valid && ref_legal(bus.instr)) begin
        p_in1   = mreg[bus.instr[25:21]];
        p_in2   = (bus.instr[31:26] != 6'd0) ? {{16{bus.instr[15]}}, bus.instr[15:0]}
                                             : mreg[bus.instr[20:16]];
        p_shamt = bus.instr[15:11];
        p_ctrl  = ref_ctrl(bus.instr);
        res     = ref_result(bus.instr, mreg[bus.instr[25:21]], mreg[bus.instr[20:16]]);
        p_waddr = bus.instr[25:21];
        p_wdata = res[31:0];
        p_flags = {res[32], res[31:0] == 32'd0, res[31]};
        pend    = 1'b1;
        pend_at = cyc + 3;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [4:0] fn);
    return {6'd0, rs, rt, sh, 6'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [4:0]  fn;
    logic [31:0] r;
    k = $urandom_range(0, 13);
    r = $urandom;
    case (k)
      0, 1, 2, 3, 4, 5, 6: fn = 5'(k);
      7, 8, 9:             fn = 5'(k + 5);
      13:                  fn = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(7, 11))
                                                            : 5'($urandom_range(15, 31));
      default:             fn = r[4:0];
    endcase
    if (k == 10)      r[31:26] = 6'd1;
    else if (k == 11) r[31:26] = 6'd2;
    else if (k == 12) r[31:26] = 6'($urandom_range(3, 63));
    else begin
      r[31:26] = 6'd0;
      r[4:0]   = fn;
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] ins);
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    for (int i = 0; i < 32; i++)
      init_val[i] = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    init_val[0] = 32'd0;          init_val[2] = 32'd10;
    init_val[3] = 32'hFFFF_FFFF;  init_val[4] = 32'd1;
    init_val[5] = 32'h8000_0000;  init_val[6] = 32'd1;
    init_val[7] = 32'd33;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    do_load = 1'b0;

    issue(rtype(5'd3, 5'd4, 5'd0, 5'b00000));     // add   r3, r4
    issue(rtype(5'd6, 5'd7, 5'd0, 5'b01100));     // shllv r6, r7
    issue({6'd1, 5'd2, 5'd0, 16'hFFF6});          // addi  r2, -10
    issue(rtype(5'd5, 5'd0, 5'd4, 5'b00110));     // shra  r5, 4
    issue(rtype(5'd1, 5'd2, 5'd0, 5'b11111));     // illegal funct

    // Valid held high across two issues, then reset lands in the second one's EXEC.
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr       = rtype(5'd8, 5'd9, 5'd0, 5'b00000);
    repeat (5) @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      bus.instr_valid = ($urandom_range(0, 2) != 0);
      bus.instr       = rand_instr();
    end
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    repeat (8) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the ALU's operand/shamt/control interface from KGP-RISC arithmetic/logic instructions.
- Accepts one instruction via valid/ready, reads two registers from the synchronous register file, and drives the ALU.
- Captures the ALU result and carry, writes the result back, and maintains the carry/zero/sign flag register.
- Sits between fetch and the register file/ALU in the core datapath.

Parameters:
DATA_W, 32, datapath and instruction width
REG_AW, 5, register-file address width
CTRL_W, 4, ALU control width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr  in  DATA_W  instruction word
instr_ready  out  1  controller can accept an instruction
rf_raddr1  out  REG_AW  register-file read port 1 (rs)
rf_raddr2  out  REG_AW  register-file read port 2 (rt)
rf_rdata1  in  DATA_W  read data 1, valid one cycle after address
rf_rdata2  in  DATA_W  read data 2, valid one cycle after address
alu_in1  out  DATA_W  ALU operand 1
alu_in2  out  DATA_W  ALU operand 2
alu_shamt  out  5  ALU immediate shift amount
alu_ctrl  out  CTRL_W  ALU control code
alu_out  in  DATA_W  ALU result (combinational)
alu_carry  in  1  ALU carry out
rf_we  out  1  write-back enable (1-cycle pulse)
rf_waddr  out  REG_AW  write-back address
rf_wdata  out  DATA_W  write-back data
flags  out  3  {carry, zero, sign}
done  out  1  instruction retired (1-cycle pulse)
illegal  out  1  instruction rejected (1-cycle pulse)

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE. instr_ready=1.
  - rf_we, done, illegal, and flags are all 0.
  - All ALU drive outputs, rf address outputs, and rf_wdata are 0. alu_ctrl=4'b0111 (ALU outputs zero).
- Instruction format:
  - op=[31:26], rs=[25:21], rt=[20:16], shamt=[15:11], funct=[4:0], imm=[15:0].
- Decode:
  - op=000000 (R-type): funct selects alu_ctrl.
    - 00000 add → 0000; 00001 comp → 0001; 00010 and → 0010; 00011 xor → 0011.
    - 00100 shll → 0100; 00101 shrl → 0101; 00110 shra → 0110.
    - 01100 shllv → 1100; 01101 shrlv → 1101; 01110 shrav → 1110.
  - op=000001 addi: ctrl 0000, alu_in2 = sign-extended imm.
  - op=000010 compi: ctrl 0001, alu_in2 = sign-extended imm.
  - Every other op/funct is illegal.
- Destination is always rs (rs ← rs op rt or imm).
- FSM: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: instr_ready=1. When instr_valid is high, latch instr, drive rf_raddr1=rs and rf_raddr2=rt, go to READ. If the decode is illegal, pulse illegal next cycle and stay in IDLE; flags unchanged; no write.
  - READ: register the read data; alu_in1 = rdata1; alu_in2 = rdata2 or sign-extended imm; alu_shamt = shamt; alu_ctrl is registered.
  - EXEC: ALU inputs are stable. At the end of the cycle, capture alu_out into rf_wdata and alu_carry into the carry staging bit.
  - WB: rf_we=1, rf_waddr=rs, done=1. Flags update in the same edge:
    - carry = alu_carry (0 for non-add ops);
    - zero = (result==0);
    - sign = result[31].
- Latency: instruction accepted at edge 0; rf_we/done asserted in cycle 3. Throughput is one instruction per 4 cycles.
- instr_ready is 0 in READ/EXEC/WB. instr_valid in those states is ignored, not queued.
- rs=0 writes normally; no hard-wired zero register in this block.
- Shift amounts: variable-shift amounts ≥32 give 0 for logical shifts and full sign-fill for shra. This is ALU behaviour; the controller passes the full rt value.
- Reset asserted mid-instruction: immediate return to IDLE, no write-back, flags cleared.

Decomposition:
- Package kgp_alu_pkg:
  - ALU control codes (ALU_ADD … ALU_SRAV, ALU_ZERO=4'b0111);
  - opcode and funct constants;
  - FSM state enum;
  - flag bit indices.
- One combinational sub-module, alu_funct_decode: instr → {alu_ctrl, use_imm, legal}.
- The ALU itself is external, connected via the alu_* ports.

Test Plan:
- add: rs=3 (0xFFFFFFFF), rt=4 (0x00000001).
  → alu_ctrl=0000; rf_we in cycle 3; waddr=3; wdata=0; flags=3'b110; done=1.
- shra: shamt=4, rs=5 (0x80000000).
  → alu_ctrl=0110, alu_shamt=4; wdata=0xF8000000; flags=3'b001.
- shllv: rs=6 (0x1), rt=7 (33).
  → alu_ctrl=1100, alu_in2=33; wdata=0; flags=3'b010.
- addi: rs=2 (10), imm=0xFFF6.
  → alu_in2=0xFFFFFFF6; wdata=0; carry=1, zero=1.
- Illegal funct 11111 with flags preset to 3'b001.
  → illegal pulse; no rf_we; flags stay 3'b001; instr_ready stays 1.
- Back-to-back instr_valid held high, then rst_n low during EXEC.
  → second instruction accepted only after WB; reset aborts with no rf_we; flags=0; state IDLE; instr_ready=1.
